spi_receiver: RTL and testbench

- SPI slave stage directly downstream of the team's SPI master generator.
- Consumes the CS, SCK and MOSI lines and drives MISO back to the master.
- Deserialises MOSI into parallel words with a one-cycle valid strobe, and serialises a host-supplied word onto MISO.
- Runs entirely in the CLK domain: SPI inputs are oversampled through synchronisers, never used as clocks.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_sync.sv | 32 +++
 rtl/spi_receiver.sv | 150 +++++++++++++++
 tb/tb_spi_receiver.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types, defaults and helpers for the SPI slave receiver.
package spi_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_t;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_SYNC_STAGES = 2;

    function automatic logic sample_on_rise(input logic ckp, input logic cph);
        return (ckp == cph);
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous SPI line, with edge strobes
// derived from the synchronised level and its one-cycle-delayed copy.
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RESET,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic              prev_reg;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_reg <= {STAGES{RESET_VAL}};
            prev_reg <= RESET_VAL;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], din};
            prev_reg <= sync_reg[STAGES-1];
        end
    end

    assign dout = sync_reg[STAGES-1];
    assign rise = sync_reg[STAGES-1] & ~prev_reg;
    assign fall = ~sync_reg[STAGES-1] & prev_reg;

endmodule

// File: rtl/spi_receiver.sv
// SPI slave: oversamples CS/SCK/MOSI in the CLK domain, deserialises MOSI into
// words and shifts a host-supplied word out on MISO.
module spi_receiver
    import spi_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CKP,
    input  logic              CPH,
    input  logic              CS,
    input  logic              SCK,
    input  logic              MOSI,
    output logic              MISO,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic sck_level_unused, sck_rise, sck_fall;
    logic cs_level_unused, cs_rise, cs_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .CLK(CLK), .RESET(RESET), .din(SCK),
        .dout(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .CLK(CLK), .RESET(RESET), .din(CS),
        .dout(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .CLK(CLK), .RESET(RESET), .din(MOSI),
        .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_state_t        state_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic              skip_reg;
    logic [DATA_W-1:0] tx_shift_reg;
    logic [DATA_W-1:0] rx_shift_reg;
    logic [DATA_W-1:0] hold_reg;
    logic              tx_ready_reg;
    logic [DATA_W-1:0] rx_data_reg;
    logic              rx_valid_reg;
    logic              frame_err_reg;

    logic              sample_edge, shift_edge, active, word_done, load_shifter;
    logic [DATA_W-1:0] next_tx_word;
    logic [DATA_W-1:0] rx_word_next;

    always_comb begin
        sample_edge  = sample_on_rise(CKP, CPH) ? sck_rise : sck_fall;
        shift_edge   = sample_on_rise(CKP, CPH) ? sck_fall : sck_rise;
        active       = (state_reg == ST_ACTIVE);
        // CS rising wins over a coincident SCK edge, so it also blocks the word-end reload
        word_done    = active && !cs_rise && sample_edge && (bit_cnt_reg == LAST_BIT);
        load_shifter = (!active && cs_fall) || word_done;
        next_tx_word = tx_ready_reg ? '0 : hold_reg;
        rx_word_next = {rx_shift_reg[DATA_W-2:0], mosi_s};
    end

    // Holding register: a load into the shifter frees it, and a same-cycle
    // tx_load refills it immediately.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hold_reg     <= '0;
            tx_ready_reg <= 1'b1;
        end else if (load_shifter) begin
            if (tx_load) begin
                hold_reg     <= tx_data;
                tx_ready_reg <= 1'b0;
            end else begin
                tx_ready_reg <= 1'b1;
            end
        end else if (tx_load && tx_ready_reg) begin
            hold_reg     <= tx_data;
            tx_ready_reg <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            skip_reg      <= 1'b0;
            tx_shift_reg  <= '0;
            rx_shift_reg  <= '0;
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_reg    <= ST_ACTIVE;
                        bit_cnt_reg  <= '0;
                        skip_reg     <= CPH;
                        tx_shift_reg <= next_tx_word;
                    end
                end
                ST_ACTIVE: begin
                    if (cs_rise) begin
                        state_reg     <= ST_IDLE;
                        frame_err_reg <= (bit_cnt_reg != '0);
                        bit_cnt_reg   <= '0;
                    end else if (sample_edge) begin
                        rx_shift_reg <= rx_word_next;
                        if (bit_cnt_reg == LAST_BIT) begin
                            rx_data_reg  <= rx_word_next;
                            rx_valid_reg <= 1'b1;
                            bit_cnt_reg  <= '0;
                            tx_shift_reg <= next_tx_word;
                            // the next shift edge would otherwise drop the new word's MSB
                            skip_reg     <= 1'b1;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                        end
                    end else if (shift_edge) begin
                        if (skip_reg) begin
                            skip_reg <= 1'b0;
                        end else begin
                            tx_shift_reg <= {tx_shift_reg[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign MISO      = active & tx_shift_reg[DATA_W-1];
    assign tx_ready  = tx_ready_reg;
    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_spi_receiver.sv
// Bench for spi_receiver: a behavioural SPI master drives frames in all four
// modes; received words and MISO bits are compared against expected words.
module tb_spi_receiver;

    localparam int DW = 8;
    localparam int SS = 2;
    localparam int H  = 6;   // CLK cycles per SCK half-period

    logic          CLK = 1'b0;
    logic          RESET, CKP, CPH, CS, SCK, MOSI;
    logic          MISO, tx_load, tx_ready, rx_valid, frame_err;
    logic [DW-1:0] tx_data, rx_data;

    spi_receiver #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
        .CLK(CLK), .RESET(RESET), .CKP(CKP), .CPH(CPH), .CS(CS), .SCK(SCK),
        .MOSI(MOSI), .MISO(MISO), .tx_data(tx_data), .tx_load(tx_load),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_err(frame_err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [DW-1:0] rx_q[$];
    int            rx_cyc_q[$];
    int            fe_cycles = 0;

    always @(negedge CLK) begin
        if (rx_valid === 1'b1) begin
            rx_q.push_back(rx_data);
            rx_cyc_q.push_back(cyc);
        end
        if (frame_err === 1'b1) fe_cycles++;
    end

    int            tests = 0;
    int            fails = 0;
    int            last_sample_cyc = 0;
    logic [DW-1:0] model_rx_data = '0;

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic clear_mon();
        rx_q.delete();
        rx_cyc_q.delete();
        fe_cycles = 0;
    endtask

    task automatic load_tx(input logic [DW-1:0] w);
        tx_data = w;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
    endtask

    // Master: mosi bits sent MSB first; MISO captured at each master sample edge.
    task automatic spi_xfer(input logic ckp, input logic cph, input int nbits,
                            input logic [31:0] mosi_vec, input bit raise_cs,
                            output logic [31:0] miso_vec);
        miso_vec = '0;
        CKP = ckp; CPH = cph; SCK = ckp;
        tick(H);
        CS = 1'b0;
        if (!cph) MOSI = mosi_vec[nbits-1];
        tick(H);
        for (int i = 0; i < nbits; i++) begin
            if (cph) begin
                SCK = ~ckp; MOSI = mosi_vec[nbits-1-i];
                tick(H);
                SCK = ckp; miso_vec = {miso_vec[30:0], MISO}; last_sample_cyc = cyc;
                tick(H);
            end else begin
                SCK = ~ckp; miso_vec = {miso_vec[30:0], MISO}; last_sample_cyc = cyc;
                tick(H);
                SCK = ckp;
                if (i + 1 < nbits) MOSI = mosi_vec[nbits-2-i];
                tick(H);
            end
        end
        if (raise_cs) begin
            CS = 1'b1;
            tick(2*H);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; CS = 1'b1; SCK = 1'b0; MOSI = 1'b0; CKP = 1'b0; CPH = 1'b0;
        tx_load = 1'b0; tx_data = '0;
        tick(3);
        tests++; if (MISO !== 1'b0) begin fails++; $display("FAIL reset_miso got=%b exp=0", MISO); end
        tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
        tests++; if (rx_data !== '0) begin fails++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        RESET = 1'b0;
        tick(4);
        $display("[TB] reset done");
    endtask

    task automatic test_mode0();
        logic [31:0] miso;
        logic [DW-1:0] got;
        clear_mon();
        load_tx(8'h3C);
        tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL m0_tx_ready_drop got=%b exp=0", tx_ready); end
        spi_xfer(1'b0, 1'b0, 8, 32'hA5, 1'b1, miso);
        model_rx_data = 8'hA5;
        got = (rx_q.size() > 0) ? rx_q[0] : 'x;
        tests++; if (rx_q.size() != 1) begin fails++; $display("FAIL m0_rx_count got=%0d exp=1", rx_q.size()); end
        tests++; if (got !== 8'hA5) begin fails++; $display("FAIL m0_rx_word got=%h exp=a5", got); end
        tests++; if (rx_data !== 8'hA5) begin fails++; $display("FAIL m0_rx_data got=%h exp=a5", rx_data); end
        tests++; if (miso[7:0] !== 8'h3C) begin fails++; $display("FAIL m0_miso got=%h exp=3c", miso[7:0]); end
        tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL m0_tx_ready got=%b exp=1", tx_ready); end
        tests++;
        if (rx_cyc_q.size() == 0 || rx_cyc_q[0] - last_sample_cyc != SS + 1) begin
            fails++;
            $display("FAIL m0_latency got=%0d exp=%0d", (rx_cyc_q.size() > 0) ? rx_cyc_q[0] - last_sample_cyc : -1, SS + 1);
        end
        tests++; if (fe_cycles != 0) begin fails++; $display("FAIL m0_frame_err got=%0d exp=0", fe_cycles); end
        tests++; if (MISO !== 1'b0) begin fails++; $display("FAIL m0_idle_miso got=%b exp=0", MISO); end
        $display("[TB] mode0 rx=%h miso=%h", got, miso[7:0]);
    endtask

    task automatic test_modes();
        logic [31:0] miso;
        logic [DW-1:0] got;
        for (int m = 1; m < 4; m++) begin
            clear_mon();
            load_tx(8'h7E);
            spi_xfer(m[1], m[0], 8, 32'h81, 1'b1, miso);
            model_rx_data = 8'h81;
            got = (rx_q.size() == 1) ? rx_q[0] : 'x;
            tests++; if (got !== 8'h81) begin fails++; $display("FAIL mode%0d_rx got=%h n=%0d exp=81", m, got, rx_q.size()); end
            tests++; if (miso[7:0] !== 8'h7E) begin fails++; $display("FAIL mode%0d_miso got=%h exp=7e", m, miso[7:0]); end
            tests++; if (fe_cycles != 0) begin fails++; $display("FAIL mode%0d_frame_err got=%0d exp=0", m, fe_cycles); end
            $display("[TB] mode%0d rx=%h miso=%h", m, got, miso[7:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] miso;
        logic [DW-1:0] a, b, g0, g1;
        int mode;
        mode = $urandom_range(0, 3);
        a = DW'($urandom); b = DW'($urandom);
        clear_mon();
        load_tx(a);
        fork
            spi_xfer(mode[1], mode[0], 16, 32'h1234, 1'b1, miso);
            begin
                int k = 0;
                while (tx_ready !== 1'b1 && k < 40) begin tick(1); k++; end
                tests++;
                if (tx_ready !== 1'b1) begin fails++; $display("FAIL b2b_refill_timeout got=%b exp=1", tx_ready); end
                else load_tx(b);
            end
        join
        model_rx_data = 8'h34;
        g0 = (rx_q.size() > 0) ? rx_q[0] : 'x;
        g1 = (rx_q.size() > 1) ? rx_q[1] : 'x;
        tests++; if (rx_q.size() != 2) begin fails++; $display("FAIL b2b_rx_count got=%0d exp=2", rx_q.size()); end
        tests++; if (g0 !== 8'h12 || g1 !== 8'h34) begin fails++; $display("FAIL b2b_rx_words got=%h,%h exp=12,34", g0, g1); end
        tests++; if (miso[15:0] !== {a, b}) begin fails++; $display("FAIL b2b_miso got=%h exp=%h", miso[15:0], {a, b}); end
        tests++; if (fe_cycles != 0) begin fails++; $display("FAIL b2b_frame_err got=%0d exp=0", fe_cycles); end
        $display("[TB] b2b mode%0d rx=%h,%h miso=%h", mode, g0, g1, miso[15:0]);
    endtask

    task automatic test_no_load();
        logic [31:0] miso;
        logic [DW-1:0] got;
        clear_mon();
        tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL noload_tx_ready got=%b exp=1", tx_ready); end
        spi_xfer(1'b0, 1'b0, 8, 32'hFF, 1'b1, miso);
        model_rx_data = 8'hFF;
        got = (rx_q.size() == 1) ? rx_q[0] : 'x;
        tests++; if (got !== 8'hFF) begin fails++; $display("FAIL noload_rx got=%h exp=ff", got); end
        tests++; if (miso[7:0] !== 8'h00) begin fails++; $display("FAIL noload_miso got=%h exp=00", miso[7:0]); end
        $display("[TB] noload rx=%h miso=%h", got, miso[7:0]);
    endtask

    task automatic test_abort();
        logic [31:0] miso;
        logic [DW-1:0] got;
        clear_mon();
        spi_xfer(1'b0, 1'b0, 3, 32'($urandom_range(0, 7)), 1'b1, miso);
        tests++; if (fe_cycles != 1) begin fails++; $display("FAIL abort_frame_err_cycles got=%0d exp=1", fe_cycles); end
        tests++; if (rx_q.size() != 0) begin fails++; $display("FAIL abort_rx_count got=%0d exp=0", rx_q.size()); end
        tests++; if (rx_data !== model_rx_data) begin fails++; $display("FAIL abort_rx_data got=%h exp=%h", rx_data, model_rx_data); end
        $display("[TB] abort after 3 bits frame_err_cycles=%0d", fe_cycles);
        clear_mon();
        spi_xfer(1'b0, 1'b0, 8, 32'h5A, 1'b1, miso);
        model_rx_data = 8'h5A;
        got = (rx_q.size() == 1) ? rx_q[0] : 'x;
        tests++; if (got !== 8'h5A) begin fails++; $display("FAIL abort_next_rx got=%h exp=5a", got); end
        tests++; if (fe_cycles != 0) begin fails++; $display("FAIL abort_next_frame_err got=%0d exp=0", fe_cycles); end
        $display("[TB] post-abort rx=%h", got);
    endtask

    task automatic test_reset_mid();
        logic [31:0] miso;
        logic [DW-1:0] got, t;
        clear_mon();
        load_tx(8'hFF);
        spi_xfer(1'b0, 1'b0, 5, 32'h15, 1'b0, miso);
        load_tx(8'h11);
        tests++; if (MISO !== 1'b1) begin fails++; $display("FAIL rstmid_pre_miso got=%b exp=1", MISO); end
        tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL rstmid_pre_tx_ready got=%b exp=0", tx_ready); end
        RESET = 1'b1;
        #1;
        tests++; if (MISO !== 1'b0) begin fails++; $display("FAIL rstmid_miso got=%b exp=0", MISO); end
        tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL rstmid_tx_ready got=%b exp=1", tx_ready); end
        tests++; if (rx_data !== '0) begin fails++; $display("FAIL rstmid_rx_data got=%h exp=00", rx_data); end
        tests++; if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin fails++; $display("FAIL rstmid_strobes got=%b%b exp=00", rx_valid, frame_err); end
        CS = 1'b1; SCK = 1'b0;
        tick(3);
        RESET = 1'b0;
        model_rx_data = '0;
        tick(4);
        clear_mon();
        t = DW'($urandom);
        load_tx(t);
        spi_xfer(1'b0, 1'b0, 8, 32'hC3, 1'b1, miso);
        model_rx_data = 8'hC3;
        got = (rx_q.size() == 1) ? rx_q[0] : 'x;
        tests++; if (got !== 8'hC3) begin fails++; $display("FAIL rstmid_next_rx got=%h n=%0d exp=c3", got, rx_q.size()); end
        tests++; if (miso[7:0] !== t) begin fails++; $display("FAIL rstmid_next_miso got=%h exp=%h", miso[7:0], t); end
        tests++; if (fe_cycles != 0) begin fails++; $display("FAIL rstmid_next_frame_err got=%0d exp=0", fe_cycles); end
        $display("[TB] post-reset rx=%h miso=%h", got, miso[7:0]);
    endtask

    task automatic test_random();
        logic [31:0] miso;
        logic [DW-1:0] got, rx_w, tx_w, exp_miso;
        int mode, lat;
        bit loaded;
        for (int it = 0; it < 10; it++) begin
            mode   = $urandom_range(0, 3);
            rx_w   = DW'($urandom);
            tx_w   = DW'($urandom);
            loaded = 1'($urandom_range(0, 1));
            exp_miso = loaded ? tx_w : '0;
            clear_mon();
            if (loaded) load_tx(tx_w);
            spi_xfer(mode[1], mode[0], 8, 32'(rx_w), 1'b1, miso);
            model_rx_data = rx_w;
            got = (rx_q.size() == 1) ? rx_q[0] : 'x;
            lat = (rx_cyc_q.size() > 0) ? rx_cyc_q[0] - last_sample_cyc : -1;
            tests++; if (got !== rx_w) begin fails++; $display("FAIL rand%0d_rx got=%h exp=%h", it, got, rx_w); end
            tests++; if (miso[7:0] !== exp_miso) begin fails++; $display("FAIL rand%0d_miso got=%h exp=%h", it, miso[7:0], exp_miso); end
            tests++; if (lat != SS + 1) begin fails++; $display("FAIL rand%0d_latency got=%0d exp=%0d", it, lat, SS + 1); end
            tests++; if (tx_ready !== 1'b1 || fe_cycles != 0) begin fails++; $display("FAIL rand%0d_status got=ready%b fe%0d exp=ready1 fe0", it, tx_ready, fe_cycles); end
            $display("[TB] rand%0d mode%0d load=%0d rx=%h miso=%h", it, mode, loaded, got, miso[7:0]);
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_modes();
        test_back_to_back();
        test_no_load();
        test_abort();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
